vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: position counters, syncs, display enable,
// line/frame strobes and a frame counter. Option macro: VGA_SYNC_ALIGN_EN.
module vga_timing_gen #(
    parameter int   H_DISPLAY   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_DISPLAY   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [8:0] frame_no
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS   = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS   = 10'(V_DISPLAY);
    localparam logic [9:0] HS_LO   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_HI   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_LO   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_HI   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    // run_q is clear for the first clock after reset so that the first
    // clock with rst_n high presents (0,0) together with both strobes.
    logic       run_q;
    logic [9:0] hpos_q;
    logic [9:0] vpos_q;
    logic [8:0] frame_q;
    logic       ls_q;
    logic       fs_q;
    logic       hs_q;
    logic       vs_q;
    logic       de_q;

    logic       h_wrap;
    logic       v_wrap;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic [8:0] f_nxt;
    logic       hs_nxt;
    logic       vs_nxt;
    logic       de_nxt;
    logic       ls_nxt;
    logic       fs_nxt;

    // Next raster position and frame count; position holds at (0,0) until running.
    always_comb begin
        h_wrap = (hpos_q == H_LAST);
        v_wrap = (vpos_q == V_LAST);
        h_nxt  = hpos_q;
        v_nxt  = vpos_q;
        f_nxt  = frame_q;
        if (run_q) begin
            h_nxt = h_wrap ? 10'd0 : hpos_q + 10'd1;
            if (h_wrap) begin
                v_nxt = v_wrap ? 10'd0 : vpos_q + 10'd1;
            end
            if (h_wrap && v_wrap) begin
                f_nxt = frame_q + 9'd1;
            end
        end
    end

    // Decode the next position so every flag lands in the same cycle as it.
    always_comb begin
        hs_nxt = (h_nxt >= HS_LO) && (h_nxt < HS_HI);
        vs_nxt = (v_nxt >= VS_LO) && (v_nxt < VS_HI);
        de_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
        ls_nxt = (h_nxt == 10'd0);
        fs_nxt = (h_nxt == 10'd0) && (v_nxt == 10'd0);
    end

    // Counter, strobe and sync registers; reset parks everything inactive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            hpos_q  <= '0;
            vpos_q  <= '0;
            frame_q <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            hs_q    <= ~SYNC_ACTIVE;
            vs_q    <= ~SYNC_ACTIVE;
            de_q    <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            hpos_q  <= h_nxt;
            vpos_q  <= v_nxt;
            frame_q <= f_nxt;
            ls_q    <= ls_nxt;
            fs_q    <= fs_nxt;
            hs_q    <= hs_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vs_q    <= vs_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            de_q    <= de_nxt;
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    logic hs_d;
    logic vs_d;
    logic de_d;

    // Extra stage for a consumer that registers RGB once more.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_d <= ~SYNC_ACTIVE;
            vs_d <= ~SYNC_ACTIVE;
            de_d <= 1'b0;
        end else begin
            hs_d <= hs_q;
            vs_d <= vs_q;
            de_d <= de_q;
        end
    end

    assign hsync      = hs_d;
    assign vsync      = vs_d;
    assign display_on = de_d;
`else
    assign hsync      = hs_q;
    assign vsync      = vs_q;
    assign display_on = de_q;
`endif

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_no    = frame_q;

endmodule
